// File: rtl/keypad_pkg.sv
// -----------------------------------------------------------------------------
// keypad_pkg
//   Shared definitions for the keypad matrix scanner:
//     scan_state_t : debounce FSM states (IDLE, DEB_PRESS, PRESSED, DEB_REL)
//     NO_KEY       : key code meaning "no key"; never emitted as an event
//     code_of()    : row/column to key code, row*cols + col + 1
// -----------------------------------------------------------------------------
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DEB_PRESS = 2'd1,
      PRESSED   = 2'd2,
      DEB_REL   = 2'd3
   } scan_state_t;

   localparam int unsigned NO_KEY = 32'd0;

   // Codes start at 1 so that 0 can mean "no key".
   function automatic int unsigned code_of(input int unsigned row,
                                           input int unsigned col,
                                           input int unsigned cols);
      code_of = row * cols + col + 32'd1;
   endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// -----------------------------------------------------------------------------
// keypad_scan_tick
//   Row-slot divider and one-hot row rotator.
//   Ports:
//     sys_clk   in   clock
//     sys_rst   in   synchronous active-high reset
//     row_out   out  ROWS one-hot row strobe (bit0 = row 0, row 0 after reset)
//     tick      out  high on the last sys_clk cycle of each SCAN_DIV slot
//     frame_end out  tick of the last row (completes a scan frame)
// -----------------------------------------------------------------------------
module keypad_scan_tick #(
   parameter int ROWS     = 4,
   parameter int SCAN_DIV = 1000
) (
   input  logic            sys_clk,
   input  logic            sys_rst,
   output logic [ROWS-1:0] row_out,
   output logic            tick,
   output logic            frame_end
);

   localparam int               DIV_W    = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic [DIV_W-1:0] div_r;
   logic [ROWS-1:0]  row_r;
   logic             tick_s;

   // Slot ends when the divider reaches its last count.
   always_comb begin
      tick_s = (div_r == DIV_LAST);
   end

   // Slot divider: counts 0..SCAN_DIV-1 and wraps.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         div_r <= '0;
      end else if (tick_s) begin
         div_r <= '0;
      end else begin
         div_r <= div_r + DIV_W'(1);
      end
   end

   // Row strobe: rotate left at the end of each slot, last row wraps to row 0.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         row_r <= ROWS'(1);
      end else if (tick_s) begin
         row_r <= {row_r[ROWS-2:0], row_r[ROWS-1]};
      end else begin
         row_r <= row_r;
      end
   end

   assign row_out   = row_r;
   assign tick      = tick_s;
   assign frame_end = tick_s & row_r[ROWS-1];

endmodule

// File: rtl/keypad_matrix_scanner.sv
// -----------------------------------------------------------------------------
// keypad_matrix_scanner
//   Scans a ROWS x COLS key matrix, debounces over whole scan frames, rejects
//   multi-key frames and emits one key-code event per press on valid/ready.
//   Ports:
//     sys_clk    in   clock
//     sys_rst    in   synchronous active-high reset
//     row_out    out  one-hot row strobe
//     col_in     in   column sense for the strobed row (pre-synchronised)
//     key_valid  out  event pending
//     key_ready  in   consumer accepts when key_valid && key_ready
//     key_code   out  event code row*COLS+col+1
//     key_held   out  code of the currently accepted key, 0 when none
//     overflow   out  sticky: an event was dropped while one was pending
//   Build option: KEYPAD_REPEAT_EN adds auto-repeat every REPEAT_FRAMES frames
//   while a key stays pressed.
// -----------------------------------------------------------------------------
module keypad_matrix_scanner
   import keypad_pkg::*;
#(
   parameter  int ROWS          = 4,
   parameter  int COLS          = 3,
   parameter  int SCAN_DIV      = 1000,
   parameter  int DEBOUNCE      = 3,
   parameter  int REPEAT_FRAMES = 50,
   localparam int CODE_W        = $clog2(ROWS * COLS + 1)
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   output logic [ROWS-1:0]   row_out,
   input  logic [COLS-1:0]   col_in,
   output logic              key_valid,
   input  logic              key_ready,
   output logic [CODE_W-1:0] key_code,
   output logic [CODE_W-1:0] key_held,
   output logic              overflow
);

   localparam int                NKEYS    = ROWS * COLS;
   localparam int                CNT_W    = $clog2(DEBOUNCE + 1);
   localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEBOUNCE - 1);
   localparam logic [CODE_W-1:0] NO_KEY_C = CODE_W'(NO_KEY);

   // Configuration sanity check at elaboration.
   if (ROWS < 2 || COLS < 1 || SCAN_DIV < 2 || DEBOUNCE < 1 || REPEAT_FRAMES < 1) begin : g_bad_cfg
      $error("keypad_matrix_scanner: illegal parameter set");
   end

   logic                  tick_s;
   logic                  frame_end_s;
   logic [(ROWS-1)*COLS-1:0] frame_r;
   logic [NKEYS-1:0]      frame_s;
   logic                  found_s;
   logic                  multi_s;
   logic [CODE_W-1:0]     hit_s;
   logic [CODE_W-1:0]     cand_s;
   scan_state_t           state_r, state_n;
   logic [CNT_W-1:0]      cnt_r, cnt_n;
   logic [CODE_W-1:0]     hold_r, hold_n;
   logic                  ev_s;
   logic [CODE_W-1:0]     ev_code_s;
   logic                  key_valid_r;
   logic [CODE_W-1:0]     key_code_r;
   logic [CODE_W-1:0]     key_held_r;
   logic                  overflow_r;
`ifdef KEYPAD_REPEAT_EN
   localparam int               RF_W    = $clog2(REPEAT_FRAMES + 1);
   localparam logic [RF_W-1:0]  RF_LAST = RF_W'(REPEAT_FRAMES - 1);
   logic [RF_W-1:0]             rep_r, rep_n;
`endif

   keypad_scan_tick #(
      .ROWS     (ROWS),
      .SCAN_DIV (SCAN_DIV)
   ) u_scan_tick (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .row_out   (row_out),
      .tick      (tick_s),
      .frame_end (frame_end_s)
   );

   // Frame buffer: capture columns of every row except the last; the last row
   // is taken live from col_in on the frame-end tick.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         frame_r <= '0;
      end else begin
         for (int r = 0; r < ROWS - 1; r++) begin
            if (tick_s && row_out[r]) begin
               frame_r[r*COLS +: COLS] <= col_in;
            end else begin
               frame_r[r*COLS +: COLS] <= frame_r[r*COLS +: COLS];
            end
         end
      end
   end

   // Frame decode: exactly one contact gives its code, none or several give NO_KEY.
   always_comb begin
      frame_s = {col_in, frame_r};
      found_s = 1'b0;
      multi_s = 1'b0;
      hit_s   = NO_KEY_C;
      for (int k = 0; k < NKEYS; k++) begin
         multi_s = multi_s | (found_s & frame_s[k]);
         hit_s   = (frame_s[k] & ~found_s) ? CODE_W'(code_of(k / COLS, k % COLS, COLS)) : hit_s;
         found_s = found_s | frame_s[k];
      end
      if (found_s && !multi_s) begin
         cand_s = hit_s;
      end else begin
         cand_s = NO_KEY_C;
      end
   end

   // Debounce FSM next state; only frame ends move it.
   always_comb begin
      state_n   = state_r;
      cnt_n     = cnt_r;
      hold_n    = hold_r;
      ev_s      = 1'b0;
      ev_code_s = hold_r;
`ifdef KEYPAD_REPEAT_EN
      rep_n     = rep_r;
`endif
      if (frame_end_s) begin
         case (state_r)
            IDLE: begin
               if (cand_s != NO_KEY_C) begin
                  hold_n = cand_s;
                  if (DEBOUNCE == 1) begin
                     state_n   = PRESSED;
                     ev_s      = 1'b1;
                     ev_code_s = cand_s;
                  end else begin
                     state_n = DEB_PRESS;
                     cnt_n   = CNT_W'(1);
                  end
               end else begin
                  state_n = IDLE;
               end
            end
            DEB_PRESS: begin
               if (cand_s == hold_r) begin
                  if (cnt_r == DEB_LAST) begin
                     state_n = PRESSED;
                     cnt_n   = '0;
                     ev_s    = 1'b1;
                  end else begin
                     cnt_n = cnt_r + CNT_W'(1);
                  end
               end else begin
                  state_n = IDLE;
                  cnt_n   = '0;
               end
            end
            PRESSED: begin
               if (cand_s == hold_r) begin
                  state_n = PRESSED;
`ifdef KEYPAD_REPEAT_EN
                  if (rep_r == RF_LAST) begin
                     rep_n = '0;
                     ev_s  = 1'b1;
                  end else begin
                     rep_n = rep_r + RF_W'(1);
                  end
`endif
               end else if (DEBOUNCE == 1) begin
                  state_n = IDLE;
               end else begin
                  state_n = DEB_REL;
                  cnt_n   = CNT_W'(1);
               end
            end
            DEB_REL: begin
               if (cand_s == hold_r) begin
                  state_n = PRESSED;
                  cnt_n   = '0;
               end else if (cnt_r == DEB_LAST) begin
                  state_n = IDLE;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt_r + CNT_W'(1);
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         endcase
      end else begin
         state_n = state_r;
      end
`ifdef KEYPAD_REPEAT_EN
      // Repeat spacing restarts whenever PRESSED is left.
      if (state_n != PRESSED) begin
         rep_n = '0;
      end else begin
         rep_n = rep_n;
      end
`endif
   end

   // FSM state, debounce counter, held code and its registered output.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_r    <= IDLE;
         cnt_r      <= '0;
         hold_r     <= NO_KEY_C;
         key_held_r <= NO_KEY_C;
      end else begin
         state_r    <= state_n;
         cnt_r      <= cnt_n;
         hold_r     <= hold_n;
         key_held_r <= (state_n == PRESSED || state_n == DEB_REL) ? hold_n : NO_KEY_C;
      end
   end

`ifdef KEYPAD_REPEAT_EN
   // Auto-repeat frame counter.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         rep_r <= '0;
      end else begin
         rep_r <= rep_n;
      end
   end
`endif

   // Event handshake: a new event loads if the slot is free or being accepted
   // this cycle; otherwise it is dropped and overflow sticks.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         key_valid_r <= 1'b0;
         key_code_r  <= NO_KEY_C;
         overflow_r  <= 1'b0;
      end else if (ev_s) begin
         if (!key_valid_r || key_ready) begin
            key_valid_r <= 1'b1;
            key_code_r  <= ev_code_s;
         end else begin
            overflow_r  <= 1'b1;
         end
      end else if (key_valid_r && key_ready) begin
         key_valid_r <= 1'b0;
      end else begin
         key_valid_r <= key_valid_r;
      end
   end

   assign key_valid = key_valid_r;
   assign key_code  = key_code_r;
   assign key_held  = key_held_r;
   assign overflow  = overflow_r;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_matrix_scanner
//   Directed self-checking bench: SCAN_DIV=4, DEBOUNCE=3, REPEAT_FRAMES=5,
//   so one scan frame is 16 clocks. A key-matrix model drives col_in from
//   row_out; key changes are applied at frame boundaries.
// -----------------------------------------------------------------------------
module tb_keypad_matrix_scanner;

   localparam int ROWS   = 4;
   localparam int COLS   = 3;
   localparam int CODE_W = 4;
   localparam int FRAME  = 16;

   logic              sys_clk = 1'b0;
   logic              sys_rst = 1'b1;
   logic [ROWS-1:0]   row_out;
   logic [COLS-1:0]   col_in;
   logic              key_valid;
   logic              key_ready = 1'b0;
   logic [CODE_W-1:0] key_code;
   logic [CODE_W-1:0] key_held;
   logic              overflow;

   logic [ROWS*COLS-1:0] key_mat = '0;
   int                n_cmp = 0;
   int                n_bad = 0;
   int                ev_cnt = 0;
   logic [CODE_W-1:0] last_code = '0;
   int                base;

   keypad_matrix_scanner #(
      .ROWS          (ROWS),
      .COLS          (COLS),
      .SCAN_DIV      (4),
      .DEBOUNCE      (3),
      .REPEAT_FRAMES (5)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .row_out   (row_out),
      .col_in    (col_in),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_code  (key_code),
      .key_held  (key_held),
      .overflow  (overflow)
   );

   always #5 sys_clk = ~sys_clk;

   // Key matrix: a closed key connects its row strobe to its column.
   always_comb begin
      col_in = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            col_in[c] = col_in[c] | (row_out[r] & key_mat[r*COLS+c]);
         end
      end
   end

   // Accepted-event recorder.
   always @(posedge sys_clk) begin
      if (!sys_rst && key_valid && key_ready) begin
         ev_cnt    <= ev_cnt + 1;
         last_code <= key_code;
      end
   end

   task automatic do_reset();
      sys_rst = 1'b1;
      key_mat = '0;
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      sys_rst = 1'b0;
   endtask

   task automatic test_reset();
      sys_rst   = 1'b1;
      key_mat   = '0;
      key_ready = 1'b0;
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      n_cmp++; if (row_out !== 4'b0001) begin n_bad++; $display("FAIL reset_row: got %b want %b", row_out, 4'b0001); end
      n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", key_valid); end
      n_cmp++; if (key_code !== 4'd0) begin n_bad++; $display("FAIL reset_code: got %0d want 0", key_code); end
      n_cmp++; if (key_held !== 4'd0) begin n_bad++; $display("FAIL reset_held: got %0d want 0", key_held); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
      sys_rst = 1'b0;
      repeat (3) @(negedge sys_clk);
      n_cmp++; if (row_out !== 4'b0001) begin n_bad++; $display("FAIL slot0_row: got %b want %b", row_out, 4'b0001); end
      @(negedge sys_clk);
      n_cmp++; if (row_out !== 4'b0010) begin n_bad++; $display("FAIL slot1_row: got %b want %b", row_out, 4'b0010); end
      repeat (12) @(negedge sys_clk);
      n_cmp++; if (row_out !== 4'b0001) begin n_bad++; $display("FAIL wrap_row: got %b want %b", row_out, 4'b0001); end
   endtask

   task automatic test_press();
      do_reset();
      key_ready = 1'b1;
      base      = ev_cnt;
      key_mat   = 12'd1 << 5;                // r1c2 -> code 6
      repeat (3*FRAME - 1) @(negedge sys_clk);
      n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL press_early: valid got %b want 0", key_valid); end
      @(negedge sys_clk);
      n_cmp++; if (key_valid !== 1'b1) begin n_bad++; $display("FAIL press_valid: got %b want 1", key_valid); end
      n_cmp++; if (key_code !== 4'd6) begin n_bad++; $display("FAIL press_code: got %0d want 6", key_code); end
      n_cmp++; if (key_held !== 4'd6) begin n_bad++; $display("FAIL press_held: got %0d want 6", key_held); end
      @(negedge sys_clk);
      n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL press_accept: valid got %b want 0", key_valid); end
      repeat (FRAME - 1) @(negedge sys_clk);
      key_mat = '0;
      repeat (3*FRAME - 1) @(negedge sys_clk);
      n_cmp++; if (key_held !== 4'd6) begin n_bad++; $display("FAIL release_held: got %0d want 6", key_held); end
      @(negedge sys_clk);
      n_cmp++; if (key_held !== 4'd0) begin n_bad++; $display("FAIL release_done: held got %0d want 0", key_held); end
      n_cmp++; if (ev_cnt - base !== 1) begin n_bad++; $display("FAIL press_count: got %0d want 1", ev_cnt - base); end
   endtask

   task automatic test_bounce();
      do_reset();
      key_ready = 1'b1;
      base      = ev_cnt;
      key_mat   = 12'd1;
      repeat (2*FRAME) @(negedge sys_clk);
      key_mat   = '0;
      repeat (FRAME) @(negedge sys_clk);
      key_mat   = 12'd1;
      repeat (2*FRAME) @(negedge sys_clk);
      n_cmp++; if (key_held !== 4'd0) begin n_bad++; $display("FAIL bounce_held: got %0d want 0", key_held); end
      key_mat   = '0;
      repeat (3*FRAME) @(negedge sys_clk);
      n_cmp++; if (ev_cnt - base !== 0) begin n_bad++; $display("FAIL bounce_count: got %0d want 0", ev_cnt - base); end
   endtask

   task automatic test_multi();
      do_reset();
      key_ready = 1'b1;
      base      = ev_cnt;
      key_mat   = 12'd1 | (12'd1 << 7);      // r0c0 + r2c1
      repeat (5*FRAME) @(negedge sys_clk);
      n_cmp++; if (key_held !== 4'd0) begin n_bad++; $display("FAIL multi_held: got %0d want 0", key_held); end
      n_cmp++; if (ev_cnt - base !== 0) begin n_bad++; $display("FAIL multi_count: got %0d want 0", ev_cnt - base); end
      key_mat   = '0;
      repeat (FRAME) @(negedge sys_clk);
   endtask

   task automatic test_backpressure();
      do_reset();
      key_ready = 1'b0;
      base      = ev_cnt;
      key_mat   = 12'd1;                     // code 1
      repeat (4*FRAME) @(negedge sys_clk);
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL bp_first_ovf: got %b want 0", overflow); end
      key_mat   = '0;
      repeat (3*FRAME) @(negedge sys_clk);
      key_mat   = 12'd1 << 11;               // r3c2 -> code 12
      repeat (4*FRAME) @(negedge sys_clk);
      n_cmp++; if (key_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b want 1", key_valid); end
      n_cmp++; if (key_code !== 4'd1) begin n_bad++; $display("FAIL bp_code: got %0d want 1", key_code); end
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL bp_overflow: got %b want 1", overflow); end
      n_cmp++; if (key_held !== 4'd12) begin n_bad++; $display("FAIL bp_held: got %0d want 12", key_held); end
      key_mat   = '0;
      repeat (3*FRAME) @(negedge sys_clk);
      key_ready = 1'b1;
      @(negedge sys_clk);
      n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: valid got %b want 0", key_valid); end
      n_cmp++; if (last_code !== 4'd1) begin n_bad++; $display("FAIL bp_accepted: code got %0d want 1", last_code); end
      repeat (2*FRAME) @(negedge sys_clk);
      n_cmp++; if (ev_cnt - base !== 1) begin n_bad++; $display("FAIL bp_count: got %0d want 1", ev_cnt - base); end
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL bp_sticky: got %b want 1", overflow); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      key_ready = 1'b0;
      key_mat   = 12'd1 << 3;                // r1c0 -> code 4
      repeat (3*FRAME + 6) @(negedge sys_clk);
      n_cmp++; if (key_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pending: valid got %b want 1", key_valid); end
      sys_rst = 1'b1;
      @(negedge sys_clk);
      n_cmp++; if (key_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b want 0", key_valid); end
      n_cmp++; if (key_held !== 4'd0) begin n_bad++; $display("FAIL mid_held: got %0d want 0", key_held); end
      n_cmp++; if (row_out !== 4'b0001) begin n_bad++; $display("FAIL mid_row: got %b want %b", row_out, 4'b0001); end
      key_mat = '0;
      sys_rst = 1'b0;
   endtask

   task automatic test_repeat();
      int exp_ev;
`ifdef KEYPAD_REPEAT_EN
      exp_ev = 4;                            // frames 3, 8, 13, 18
`else
      exp_ev = 1;
`endif
      do_reset();
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rep_ovf_cleared: got %b want 0", overflow); end
      key_ready = 1'b1;
      base      = ev_cnt;
      key_mat   = 12'd1 << 6;                // r2c0 -> code 7
      repeat (20*FRAME) @(negedge sys_clk);
      key_mat   = '0;
      repeat (3*FRAME) @(negedge sys_clk);
      n_cmp++; if (ev_cnt - base !== exp_ev) begin n_bad++; $display("FAIL rep_count: got %0d want %0d", ev_cnt - base, exp_ev); end
      n_cmp++; if (last_code !== 4'd7) begin n_bad++; $display("FAIL rep_code: got %0d want 7", last_code); end
   endtask

   initial begin
      test_reset();
      test_press();
      test_bounce();
      test_multi();
      test_backpressure();
      test_reset_mid();
      test_repeat();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
